// File: rtl/clight_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clight_pkg
//  Description : Shared constants for the multi-switch light controller.
//                Holds the switch count, the default debounce and on-time
//                lengths, the matching default counter widths, and a small
//                parity helper used to decide whether a change vector
//                toggles the lamp.
//  Revision    : 1.0  initial release
// ============================================================================
package clight_pkg;

    // Number of independent mechanical switches controlling the lamp
    localparam int N_SW = 3;

    // Default configuration values
    localparam int DEB_CYCLES_DEF     = 4;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    // Counter widths for the default configuration. Each counter must be
    // able to hold its terminal value without wrapping.
    localparam int DEB_CNT_W_DEF = $clog2(DEB_CYCLES_DEF + 1);
    localparam int TMR_CNT_W_DEF = $clog2(TIMEOUT_CYCLES_DEF + 1);

    typedef logic [N_SW-1:0] sw_vec_t;

    // Odd number of switch changes flips the lamp; an even number
    // (including zero) cancels out.
    function automatic logic odd_changes(input sw_vec_t ch);
        return ^ch;
    endfunction

endpackage : clight_pkg
`default_nettype wire

// File: rtl/clight_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : clight_debounce
//  Description : Two-flop synchroniser followed by a mismatch-counting
//                debouncer for one raw switch input. The debounced level
//                flips only after DEB_CYCLES consecutive synchronised samples
//                disagree with it; any agreeing sample clears the count.
//  Ports       : clk     - clock, rising edge
//                reset   - synchronous, active-high
//                d       - raw asynchronous switch level
//                q       - registered debounced level
//                q_next  - value q takes at the next edge, so the parent can
//                          react on the same edge that q changes
//  Revision    : 1.0  initial release
// ============================================================================
module clight_debounce
    import clight_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic q_next
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;

    // The sample that completes the run of DEB_CYCLES mismatches flips the
    // output directly, which is why the compare is against DEB_CYCLES-1.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // During reset the next registered value is 0 regardless of the inputs.
    assign q      = db_q;
    assign q_next = reset ? 1'b0 : db_d;

endmodule : clight_debounce
`default_nettype wire

// File: rtl/clight_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clight_ctrl
//  Description : Multi-switch (staircase style) light controller. Three raw
//                switches are synchronised and debounced; every accepted
//                change of odd parity toggles the registered lamp output.
//                An optional auto-off timer turns the lamp off after
//                TIMEOUT_CYCLES cycles without switch activity.
//  Config      : CLIGHT_TIMEOUT_EN - when defined, the auto-off timer is
//                built; otherwise timeout_pulse is tied low and
//                TIMEOUT_CYCLES has no effect.
//  Ports       : clk           - clock, rising edge
//                reset         - synchronous, active-high
//                sw[2:0]       - raw asynchronous switch levels
//                sw_db[2:0]    - debounced switch levels
//                light         - lamp drive, 1 = on
//                toggle_pulse  - one-cycle strobe, lamp changed by switches
//                timeout_pulse - one-cycle strobe, lamp forced off by timer
//  Revision    : 1.0  initial release
// ============================================================================
module clight_ctrl
    import clight_pkg::*;
#(
    parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw,
    output logic [2:0] sw_db,
    output logic       light,
    output logic       toggle_pulse,
    output logic       timeout_pulse
);

    sw_vec_t sw_db_q;
    sw_vec_t sw_db_d;
    sw_vec_t ch;
    logic    toggle;

    logic    light_q;
    logic    light_d;
    logic    toggle_pulse_q;
    logic    timeout_pulse_q;
    logic    timeout_pulse_d;

    // ------------------------------------------------------------------
    // Per-switch synchroniser + debouncer
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N_SW; i++) begin : g_sw
            clight_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .d      (sw[i]),
                .q      (sw_db_q[i]),
                .q_next (sw_db_d[i])
            );
        end
    endgenerate

    // Changes accepted on the coming edge. Two simultaneous changes cancel;
    // three behave like one.
    assign ch     = sw_db_d ^ sw_db_q;
    assign toggle = odd_changes(ch);

`ifdef CLIGHT_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Auto-off timer
    // ------------------------------------------------------------------
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             tmr_hit;

    // The timer is 0 on the edge the lamp turns on and reaches
    // TIMEOUT_CYCLES-1 one edge before the lamp must go off, so the lamp is
    // high for exactly TIMEOUT_CYCLES cycles. A switch toggle on the same
    // edge takes priority over the timeout.
    assign tmr_hit = light_q && !toggle && (tmr_q == TMR_LAST);

    always_comb begin
        tmr_d = '0;
        if (light_q && !toggle && !tmr_hit) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    always_comb begin
        light_d         = light_q ^ toggle;
        timeout_pulse_d = 1'b0;
        if (tmr_hit) begin
            light_d         = 1'b0;
            timeout_pulse_d = 1'b1;
        end
    end
`else
    // Without the timer the on-time parameter is intentionally unused.
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);

    always_comb begin
        light_d         = light_q ^ toggle;
        timeout_pulse_d = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Lamp and strobe registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            light_q         <= 1'b0;
            toggle_pulse_q  <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            light_q         <= light_d;
            toggle_pulse_q  <= toggle;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign sw_db         = sw_db_q;
    assign light         = light_q;
    assign toggle_pulse  = toggle_pulse_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule : clight_ctrl
`default_nettype wire
